// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column drive, synchronized row sampling, per-scan classification,
// debounced press/release FSM. Define KEYPAD_REPEAT_EN to enable auto-repeat strobes.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV       = 1000,
    parameter int unsigned DEBOUNCE_SCANS = 4,
    parameter int unsigned REPEAT_SCANS   = 50
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    typedef enum logic [1:0] {StIdle, StDebounce, StPressed, StRelease} state_e;

    localparam logic [15:0] SlotLast = 16'(SCAN_DIV - 1);
    localparam logic [3:0]  DbLast   = 4'(DEBOUNCE_SCANS);

    logic [3:0]  row_s1, row_s2;
    logic [15:0] slot_cnt;
    logic [1:0]  col_idx;
    logic [1:0]  acc_hits;
    logic [3:0]  acc_code;
    logic        slot_last, scan_done;
    logic [1:0]  col_hits, col_row, tot_hits;
    logic [2:0]  hit_sum;
    logic [3:0]  tot_code;
    logic        scan_none, scan_single;

    state_e      state;
    logic [3:0]  cnt;
    logic [3:0]  cand;
`ifdef KEYPAD_REPEAT_EN
    logic [15:0] rep_cnt;
`endif

    assign col_out   = ~(4'b0001 << col_idx);
    assign slot_last = (slot_cnt == SlotLast);
    assign scan_done = slot_last && (col_idx == 2'd3);

    // Low rows in the current column, saturating at two; combined with earlier columns.
    always_comb begin
        col_hits = 2'd0;
        col_row  = 2'd0;
        for (int r = 0; r < 4; r++) begin
            if (!row_s2[r]) begin
                col_row = 2'(r);
                if (col_hits != 2'd2) col_hits = col_hits + 2'd1;
            end
        end
        hit_sum     = {1'b0, acc_hits} + {1'b0, col_hits};
        tot_hits    = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
        tot_code    = (col_hits != 2'd0) ? {col_row, col_idx} : acc_code;
        scan_none   = (tot_hits == 2'd0);
        scan_single = (tot_hits == 2'd1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_s1   <= 4'd0;
            row_s2   <= 4'd0;
            slot_cnt <= 16'd0;
            col_idx  <= 2'd0;
            acc_hits <= 2'd0;
            acc_code <= 4'd0;
        end else begin
            row_s1 <= row_in;
            row_s2 <= row_s1;
            if (slot_last) begin
                slot_cnt <= 16'd0;
                col_idx  <= col_idx + 2'd1;
                if (col_idx == 2'd3) begin
                    acc_hits <= 2'd0;
                    acc_code <= 4'd0;
                end else begin
                    acc_hits <= tot_hits;
                    acc_code <= tot_code;
                end
            end else begin
                slot_cnt <= slot_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            cnt       <= 4'd0;
            cand      <= 4'd0;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt   <= 16'd0;
`endif
        end else begin
            key_valid <= 1'b0;
            if (scan_done) begin
                unique case (state)
                    StIdle: begin
                        if (scan_single) begin
                            cand <= tot_code;
                            if (DbLast <= 4'd1) begin
                                state     <= StPressed;
                                key_code  <= tot_code;
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                cnt       <= 4'd0;
`ifdef KEYPAD_REPEAT_EN
                                rep_cnt   <= 16'd0;
`endif
                            end else begin
                                state <= StDebounce;
                                cnt   <= 4'd1;
                            end
                        end
                    end
                    StDebounce: begin
                        if (scan_single && tot_code == cand) begin
                            if (cnt + 4'd1 >= DbLast) begin
                                state     <= StPressed;
                                key_code  <= cand;
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                cnt       <= 4'd0;
`ifdef KEYPAD_REPEAT_EN
                                rep_cnt   <= 16'd0;
`endif
                            end else begin
                                cnt <= cnt + 4'd1;
                            end
                        end else begin
                            state <= StIdle;
                            cnt   <= 4'd0;
                        end
                    end
                    StPressed: begin
                        if (scan_none) begin
                            if (DbLast <= 4'd1) begin
                                state    <= StIdle;
                                key_held <= 1'b0;
                                cnt      <= 4'd0;
                            end else begin
                                state <= StRelease;
                                cnt   <= 4'd1;
                            end
`ifdef KEYPAD_REPEAT_EN
                            rep_cnt <= 16'd0;
                        end else if (scan_single && tot_code == key_code) begin
                            if (rep_cnt + 16'd1 >= 16'(REPEAT_SCANS)) begin
                                key_valid <= 1'b1;
                                rep_cnt   <= 16'd0;
                            end else begin
                                rep_cnt <= rep_cnt + 16'd1;
                            end
                        end else begin
                            rep_cnt <= 16'd0;
`endif
                        end
                    end
                    StRelease: begin
                        if (scan_none) begin
                            if (cnt + 4'd1 >= DbLast) begin
                                state    <= StIdle;
                                key_held <= 1'b0;
                                cnt      <= 4'd0;
                            end else begin
                                cnt <= cnt + 4'd1;
                            end
                        end else begin
                            // Bounce during release: back to pressed without a new strobe.
                            state <= StPressed;
                            cnt   <= 4'd0;
`ifdef KEYPAD_REPEAT_EN
                            rep_cnt <= 16'd0;
`endif
                        end
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=2, REPEAT_SCANS=3.
module tb_keypad_scanner;

    logic        clk;
    logic        rst_n;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] keys;
    int          checks;
    int          errors;
    int          strobes;
    int          base;

    keypad_scanner #(
        .SCAN_DIV(4),
        .DEBOUNCE_SCANS(2),
        .REPEAT_SCANS(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .row_in(row_in),
        .col_out(col_out),
        .key_code(key_code),
        .key_valid(key_valid),
        .key_held(key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Key matrix model: key bit r*4+c pulls row r low while column c is driven.
    always_comb begin
        for (int r = 0; r < 4; r++) row_in[r] = ~|(keys[r*4 +: 4] & ~col_out);
    end

    always @(posedge clk) if (rst_n && key_valid) strobes++;

    task automatic run_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input logic [15:0] mask);
        @(negedge clk);
        rst_n = 1'b0;
        keys  = mask;
        run_cycles(2);
        rst_n = 1'b1;
        base  = strobes;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst_n = 1'b0;
        keys  = 16'hffff;
        run_cycles(3);
        checks++;
        if (col_out !== 4'b1110) begin
            errors++; $display("FAIL reset_col got %b want 1110", col_out);
        end
        checks++;
        if ({key_code, key_valid, key_held} !== 6'd0) begin
            errors++;
            $display("FAIL reset_outs got code %h valid %b held %b want 0 0 0",
                     key_code, key_valid, key_held);
        end
    endtask

    task automatic test_col_scan;
        logic [3:0] exp;
        do_reset(16'h0000);
        for (int i = 0; i <= 40; i++) begin
            if (i > 0) @(negedge clk);
            exp = ~(4'b0001 << ((i / 4) % 4));
            checks++;
            if (col_out !== exp) begin
                errors++; $display("FAIL col_scan[%0d] got %b want %b", i, col_out, exp);
            end
        end
    endtask

    task automatic test_single_press;
        do_reset(16'h0040);
        run_cycles(32);
        checks++;
        if ({key_valid, key_held, key_code} !== {1'b1, 1'b1, 4'd6}) begin
            errors++;
            $display("FAIL press_entry got valid %b held %b code %0d want 1 1 6",
                     key_valid, key_held, key_code);
        end
        run_cycles(1);
        checks++;
        if (key_valid !== 1'b0) begin
            errors++; $display("FAIL strobe_width got %b want 0", key_valid);
        end
        run_cycles(47);
        keys = 16'h0000;
        run_cycles(16);
        checks++;
        if (key_held !== 1'b1) begin
            errors++; $display("FAIL held_release1 got %b want 1", key_held);
        end
        run_cycles(16);
        checks++;
        if (key_held !== 1'b0) begin
            errors++; $display("FAIL held_release2 got %b want 0", key_held);
        end
        checks++;
        if (strobes - base !== 1) begin
            errors++; $display("FAIL press_strobes got %0d want 1", strobes - base);
        end
        run_cycles(32);
        checks++;
        if (key_code !== 4'd6) begin
            errors++; $display("FAIL code_kept got %0d want 6", key_code);
        end
    endtask

    task automatic test_glitch;
        do_reset(16'h0001);
        run_cycles(16);
        keys = 16'h0000;
        run_cycles(48);
        checks++;
        if ({strobes - base, key_held} !== {32'd0, 1'b0}) begin
            errors++;
            $display("FAIL glitch got strobes %0d held %b want 0 0", strobes - base, key_held);
        end
        keys = 16'h0001;
        run_cycles(33);
        checks++;
        if ({strobes - base, key_held} !== {32'd1, 1'b1}) begin
            errors++;
            $display("FAIL glitch_repress got strobes %0d held %b want 1 1",
                     strobes - base, key_held);
        end
    endtask

    task automatic test_multi;
        do_reset(16'h0420);
        run_cycles(64);
        checks++;
        if ({strobes - base, key_held} !== {32'd0, 1'b0}) begin
            errors++;
            $display("FAIL multi got strobes %0d held %b want 0 0", strobes - base, key_held);
        end
        keys = 16'h0020;
        run_cycles(33);
        checks++;
        if ({strobes - base, key_code} !== {32'd1, 4'd5}) begin
            errors++;
            $display("FAIL multi_then_single got strobes %0d code %0d want 1 5",
                     strobes - base, key_code);
        end
    endtask

    task automatic test_other_key;
        do_reset(16'h0002);
        run_cycles(33);
        keys = 16'h0004;
        run_cycles(48);
        checks++;
        if ({strobes - base, key_code, key_held} !== {32'd1, 4'd1, 1'b1}) begin
            errors++;
            $display("FAIL other_key got strobes %0d code %0d held %b want 1 1 1",
                     strobes - base, key_code, key_held);
        end
        keys = 16'h0000;
        run_cycles(16);
        keys = 16'h0004;
        run_cycles(16);
        checks++;
        if ({strobes - base, key_code, key_held} !== {32'd1, 4'd1, 1'b1}) begin
            errors++;
            $display("FAIL release_bounce got strobes %0d code %0d held %b want 1 1 1",
                     strobes - base, key_code, key_held);
        end
        keys = 16'h0000;
        run_cycles(32);
        checks++;
        if (key_held !== 1'b0) begin
            errors++; $display("FAIL other_release got %b want 0", key_held);
        end
        keys = 16'h0004;
        run_cycles(33);
        checks++;
        if ({strobes - base, key_code} !== {32'd2, 4'd2}) begin
            errors++;
            $display("FAIL new_press got strobes %0d code %0d want 2 2", strobes - base, key_code);
        end
    endtask

    task automatic test_reset_mid_press;
        do_reset(16'h8000);
        run_cycles(33);
        checks++;
        if ({strobes - base, key_code, key_held} !== {32'd1, 4'd15, 1'b1}) begin
            errors++;
            $display("FAIL press15 got strobes %0d code %0d held %b want 1 15 1",
                     strobes - base, key_code, key_held);
        end
        run_cycles(20);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({col_out, key_code, key_valid, key_held} !== {4'b1110, 4'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset got col %b code %0d valid %b held %b want 1110 0 0 0",
                     col_out, key_code, key_valid, key_held);
        end
        run_cycles(2);
        rst_n = 1'b1;
        base  = strobes;
        run_cycles(17);
        checks++;
        if ({strobes - base, key_held} !== {32'd0, 1'b0}) begin
            errors++;
            $display("FAIL post_reset_debounce got strobes %0d held %b want 0 0",
                     strobes - base, key_held);
        end
        run_cycles(16);
        checks++;
        if ({strobes - base, key_held, key_code} !== {32'd1, 1'b1, 4'd15}) begin
            errors++;
            $display("FAIL post_reset_press got strobes %0d held %b code %0d want 1 1 15",
                     strobes - base, key_held, key_code);
        end
    endtask

    task automatic test_repeat;
        int exp;
`ifdef KEYPAD_REPEAT_EN
        exp = 3;
`else
        exp = 1;
`endif
        do_reset(16'h0008);
        run_cycles(160);
        keys = 16'h0000;
        run_cycles(1);
        checks++;
        if ({strobes - base, key_code} !== {exp, 4'd3}) begin
            errors++;
            $display("FAIL repeat got strobes %0d code %0d want %0d 3",
                     strobes - base, key_code, exp);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        strobes = 0;
        base    = 0;
        keys    = 16'h0000;
        rst_n   = 1'b0;
        test_reset;
        test_col_scan;
        test_single_press;
        test_glitch;
        test_multi;
        test_other_key;
        test_reset_mid_press;
        test_repeat;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
